// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with redirect flush
// Fetches sequentially from a combinational-read RAM into a DEPTH-entry FIFO.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        deq,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [3:0]  count
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [3:0]  DEPTH_C   = 4'(DEPTH);
  localparam logic [31:0] RESET_ALN = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc4_mem  [DEPTH];
  logic          push;
  logic          pop;
  logic [31:0]   fetch_pc4;

  assign imem_addr = fetch_pc;
  assign fetch_pc4 = fetch_pc + 32'd4;
  assign valid_out = (count != 4'd0);
  assign pop       = deq && valid_out && !redirect;
  // A full queue can still accept a word when the head leaves the same edge.
  assign push      = !redirect && ((count < DEPTH_C) || pop);

  // Head outputs read as NOP whenever the queue is empty, including in reset.
  assign inst_out = valid_out ? inst_mem[head] : 32'h0000_0000;
  assign pc4_out  = valid_out ? pc4_mem[head]  : 32'h0000_0000;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      fetch_pc <= RESET_ALN;
      head     <= '0;
      tail     <= '0;
      count    <= 4'd0;
    end else if (redirect) begin
      fetch_pc <= {redirect_addr[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= 4'd0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc4;
        tail     <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (CLR && push) begin
      inst_mem[tail] <= imem_data;
      pc4_mem[tail]  <= fetch_pc4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        CLK;
  logic        CLR;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        deq;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;
  logic        valid_out;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_data = word_at(imem_addr);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .deq          (deq),
    .inst_out     (inst_out),
    .pc4_out      (pc4_out),
    .valid_out    (valid_out),
    .count        (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    step();
    redirect      = 1'b0;
  endtask

  initial begin
    CLR           = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    deq           = 1'b0;
    step();
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc4", pc4_out, 32'h0);

    // Fill: first push on the first edge with CLR high.
    CLR = 1'b1;
    step();
    check("fill1_count", 32'(count), 32'd1);
    check("fill1_valid", 32'(valid_out), 32'd1);
    check("fill1_inst", inst_out, word_at(32'h0));
    step();
    step();
    step();
    check("fill_count", 32'(count), 32'd4);
    check("fill_addr", imem_addr, 32'h10);
    check("fill_inst", inst_out, word_at(32'h0));
    check("fill_pc4", pc4_out, 32'h4);
    step();
    check("stall_count", 32'(count), 32'd4);
    check("stall_addr", imem_addr, 32'h10);

    // Streaming at full occupancy.
    deq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream_inst%0d", i), inst_out, word_at(32'(4 * i)));
      check($sformatf("stream_pc4%0d", i), pc4_out, 32'(4 * i + 4));
      step();
      check($sformatf("stream_count%0d", i), 32'(count), 32'd4);
    end
    check("stream_addr", imem_addr, 32'h30);
    deq = 1'b0;

    // Redirect with three entries held, deq asserted the same edge.
    do_redirect(32'h0000_0100);
    step();
    step();
    step();
    check("pre_redir_count", 32'(count), 32'd3);
    deq = 1'b1;
    do_redirect(32'h0000_0042);
    check("redir_valid", 32'(valid_out), 32'd0);
    check("redir_count", 32'(count), 32'd0);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_inst", inst_out, 32'h0);
    check("redir_pc4", pc4_out, 32'h0);
    step();
    check("empty_deq_count", 32'(count), 32'd1);
    check("redir_head_inst", inst_out, word_at(32'h40));
    check("redir_head_pc4", pc4_out, 32'h44);
    deq = 1'b0;

    // Address wrap at the top of the 32-bit space.
    do_redirect(32'hFFFF_FFF8);
    step();
    step();
    step();
    check("wrap_count", 32'(count), 32'd3);
    check("wrap_addr", imem_addr, 32'h4);
    check("wrap_pc4_0", pc4_out, 32'hFFFF_FFFC);
    check("wrap_inst_0", inst_out, word_at(32'hFFFF_FFF8));
    deq = 1'b1;
    step();
    check("wrap_pc4_1", pc4_out, 32'h0000_0000);
    check("wrap_inst_1", inst_out, word_at(32'hFFFF_FFFC));
    step();
    check("wrap_pc4_2", pc4_out, 32'h0000_0004);
    check("wrap_inst_2", inst_out, word_at(32'h0));
    check("wrap_count_deq", 32'(count), 32'd3);
    deq = 1'b0;

    // Asynchronous reset between edges.
    do_redirect(32'h0000_0200);
    step();
    step();
    check("pre_rst_count", 32'(count), 32'd2);
    #2;
    CLR = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_inst", inst_out, 32'h0);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0300;
    deq           = 1'b1;
    step();
    check("hold_count", 32'(count), 32'd0);
    check("hold_addr", imem_addr, 32'h0);
    redirect = 1'b0;
    deq      = 1'b0;
    CLR      = 1'b1;
    step();
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_inst", inst_out, word_at(32'h0));
    check("post_rst_addr", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
